// File: rtl/ahb_ddr3_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_ddr3_slave_if
// Purpose  : Bundles the AHB slave signals and the single-command DDR3
//            controller handshake used by ahb_ddr3_slave.
// Modports : slave  - the bridge (AHB inputs in, responses and commands out)
//            master - the environment: AHB master plus controller responder
//                     (drives address/data, cmd_ready and read return data)
// Revision : 1.0 - initial release
// ============================================================================
interface ahb_ddr3_slave_if #(
    parameter int BA_BITS  = 3,
    parameter int ROW_BITS = 14,
    parameter int COL_BITS = 10
);
    // AHB side
    logic                HSEL;
    logic [31:0]         HADDR;
    logic                HWRITE;
    logic [1:0]          HTRANS;
    logic [2:0]          HSIZE;
    logic [2:0]          HBURST;
    logic [31:0]         HWDATA;
    logic                HREADY;
    logic [1:0]          HRESP;
    logic [31:0]         HRDATA;

    // Controller side
    logic                cmd_valid;
    logic                cmd_write;
    logic [BA_BITS-1:0]  cmd_ba;
    logic [ROW_BITS-1:0] cmd_row;
    logic [COL_BITS-1:0] cmd_col;
    logic [31:0]         cmd_wdata;
    logic                cmd_ready;
    logic                rd_valid;
    logic [31:0]         rd_data;

    modport slave (
        input  HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HWDATA,
        output HREADY, HRESP, HRDATA,
        output cmd_valid, cmd_write, cmd_ba, cmd_row, cmd_col, cmd_wdata,
        input  cmd_ready, rd_valid, rd_data
    );

    modport master (
        output HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HWDATA,
        input  HREADY, HRESP, HRDATA,
        input  cmd_valid, cmd_write, cmd_ba, cmd_row, cmd_col, cmd_wdata,
        output cmd_ready, rd_valid, rd_data
    );
endinterface
`default_nettype wire

// File: rtl/ahb_ddr3_slave.sv
`default_nettype none
// ============================================================================
// Module   : ahb_ddr3_slave
// Purpose  : AHB-Lite slave that turns each 32-bit word transfer into one
//            DDR3 controller command (bank/row/column decoded from HADDR),
//            stalling the AHB data phase until the controller accepts the
//            command and, for reads, returns the data word.
// Ports    : HCLK    - clock, all state changes on rising edge
//            HRESET  - asynchronous active-low reset
//            bus     - ahb_ddr3_slave_if.slave (AHB + controller handshake)
// Revision : 1.0 - initial release
// ============================================================================
module ahb_ddr3_slave #(
    parameter int BA_BITS  = 3,
    parameter int ROW_BITS = 14,
    parameter int COL_BITS = 10
) (
    input  wire logic          HCLK,
    input  wire logic          HRESET,
    ahb_ddr3_slave_if.slave    bus
);

    // Address bit positions: word address starts at bit 2
    localparam int c_COL_LSB = 2;
    localparam int c_ROW_LSB = c_COL_LSB + COL_BITS;
    localparam int c_BA_LSB  = c_ROW_LSB + ROW_BITS;
    localparam int c_TOP     = c_BA_LSB + BA_BITS;

    localparam logic [1:0] c_OKAY  = 2'b00;
    localparam logic [1:0] c_ERROR = 2'b01;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        RDWAIT = 3'd2,
        DONE   = 3'd3,
        ERR1   = 3'd4,
        ERR2   = 3'd5
    } state_t;

    state_t              state_q;
    logic                hready_q;
    logic [1:0]          hresp_q;
    logic [31:0]         hrdata_q;
    logic                cmd_valid_q;
    logic                cmd_write_q;
    logic [BA_BITS-1:0]  cmd_ba_q;
    logic [ROW_BITS-1:0] cmd_row_q;
    logic [COL_BITS-1:0] cmd_col_q;

    logic w_accept;
    logic w_bad;
    logic w_unused;

    // Address phases are only looked at while the slave is between transfers
    // (IDLE or DONE); DONE is the last data-phase cycle, so a pipelined
    // NONSEQ presented there starts the next command without a gap.
    assign w_accept = bus.HSEL && hready_q && bus.HTRANS[1] &&
                      ((state_q == IDLE) || (state_q == DONE));

    // Only aligned 32-bit words map onto a controller column
    assign w_bad = (bus.HSIZE != 3'b010) || (bus.HADDR[1:0] != 2'b00);

    // Bursts are handled beat by beat, and the top address bits select
    // nothing inside the memory.
    assign w_unused = ^{bus.HBURST, bus.HADDR[31:c_TOP]};

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q     <= IDLE;
            hready_q    <= 1'b1;
            hresp_q     <= c_OKAY;
            hrdata_q    <= 32'h0;
            cmd_valid_q <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_ba_q    <= '0;
            cmd_row_q   <= '0;
            cmd_col_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (w_accept) begin
                        cmd_write_q <= bus.HWRITE;
                        cmd_col_q   <= bus.HADDR[c_ROW_LSB-1:c_COL_LSB];
                        cmd_row_q   <= bus.HADDR[c_BA_LSB-1:c_ROW_LSB];
                        cmd_ba_q    <= bus.HADDR[c_TOP-1:c_BA_LSB];
                        hready_q    <= 1'b0;
                        if (w_bad) begin
                            state_q <= ERR1;
                            hresp_q <= c_ERROR;
                        end else begin
                            state_q     <= ISSUE;
                            hresp_q     <= c_OKAY;
                            cmd_valid_q <= 1'b1;
                        end
                    end else begin
                        state_q  <= IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= c_OKAY;
                    end
                end

                ISSUE: begin
                    // Command fields stay frozen until the controller takes it
                    if (bus.cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        if (cmd_write_q) begin
                            state_q  <= DONE;
                            hready_q <= 1'b1;
                        end else begin
                            state_q <= RDWAIT;
                        end
                    end
                end

                RDWAIT: begin
                    if (bus.rd_valid) begin
                        hrdata_q <= bus.rd_data;
                        state_q  <= DONE;
                        hready_q <= 1'b1;
                    end
                end

                ERR1: begin
                    // Second cycle of the two-cycle ERROR response
                    state_q  <= ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= c_ERROR;
                end

                ERR2: begin
                    state_q  <= IDLE;
                    hready_q <= 1'b1;
                    hresp_q  <= c_OKAY;
                end

                default: begin
                    state_q     <= IDLE;
                    hready_q    <= 1'b1;
                    hresp_q     <= c_OKAY;
                    cmd_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.HREADY    = hready_q;
    assign bus.HRESP     = hresp_q;
    assign bus.HRDATA    = hrdata_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_write = cmd_write_q;
    assign bus.cmd_ba    = cmd_ba_q;
    assign bus.cmd_row   = cmd_row_q;
    assign bus.cmd_col   = cmd_col_q;

    // Write data comes straight from the stalled data phase; the master holds
    // HWDATA steady while HREADY is low, which keeps it stable until accepted.
    assign bus.cmd_wdata = (state_q == ISSUE) ? bus.HWDATA : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_ddr3_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_ddr3_slave
// Purpose  : Directed self-checking bench for ahb_ddr3_slave. Inputs change
//            1 time unit after the rising edge; registered outputs are
//            checked at the same point, after they have settled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_ddr3_slave;

    logic HCLK;
    logic HRESET;
    int   n_assert = 0;
    int   n_fail   = 0;

    ahb_ddr3_slave_if bus ();

    ahb_ddr3_slave dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic bus_idle();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = 3'b010;
        bus.HBURST = 3'b000;
    endtask

    task automatic addr_phase(input logic [31:0] addr, input logic wr, input logic [2:0] size);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HADDR  = addr;
        bus.HWRITE = wr;
        bus.HSIZE  = size;
        bus.HBURST = 3'b000;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hready"},  32'(bus.HREADY),    32'd1);
        check({tag, "_hresp"},   32'(bus.HRESP),     32'd0);
        check({tag, "_hrdata"},  bus.HRDATA,         32'h0);
        check({tag, "_cvalid"},  32'(bus.cmd_valid), 32'd0);
        check({tag, "_cwrite"},  32'(bus.cmd_write), 32'd0);
        check({tag, "_ba"},      32'(bus.cmd_ba),    32'd0);
        check({tag, "_row"},     32'(bus.cmd_row),   32'd0);
        check({tag, "_col"},     32'(bus.cmd_col),   32'd0);
        check({tag, "_wdata"},   bus.cmd_wdata,      32'h0);
    endtask

    initial begin
        // ---------------- reset ----------------
        HRESET        = 1'b0;
        bus_idle();
        bus.HADDR     = 32'h0;
        bus.HWDATA    = 32'h5555_5555;
        bus.cmd_ready = 1'b0;
        bus.rd_valid  = 1'b0;
        bus.rd_data   = 32'h0;
        repeat (2) tick();
        check_reset_outputs("rst");
        HRESET = 1'b1;

        // ---------------- single write, immediate cmd_ready ----------------
        addr_phase(32'h0400_1008, 1'b1, 3'b010);
        bus.cmd_ready = 1'b1;
        tick();                                   // ISSUE
        bus_idle();
        bus.HWDATA = 32'hDEAD_BEEF;
        #1;
        check("wr_hready",  32'(bus.HREADY),    32'd0);
        check("wr_cvalid",  32'(bus.cmd_valid), 32'd1);
        check("wr_cwrite",  32'(bus.cmd_write), 32'd1);
        check("wr_ba",      32'(bus.cmd_ba),    32'd1);
        check("wr_row",     32'(bus.cmd_row),   32'd1);
        check("wr_col",     32'(bus.cmd_col),   32'd2);
        check("wr_wdata",   bus.cmd_wdata,      32'hDEAD_BEEF);
        tick();                                   // DONE
        bus.cmd_ready = 1'b0;
        check("wr_done_hready", 32'(bus.HREADY),    32'd1);
        check("wr_done_cvalid", 32'(bus.cmd_valid), 32'd0);
        check("wr_done_hresp",  32'(bus.HRESP),     32'd0);
        tick();                                   // IDLE

        // ---------------- read, cmd_ready delayed 3 cycles ----------------
        addr_phase(32'h0000_0004, 1'b0, 3'b010);
        tick();                                   // ISSUE #1
        bus_idle();
        for (int i = 0; i < 4; i++) begin
            check("rd_cvalid", 32'(bus.cmd_valid), 32'd1);
            check("rd_cwrite", 32'(bus.cmd_write), 32'd0);
            check("rd_ba",     32'(bus.cmd_ba),    32'd0);
            check("rd_row",    32'(bus.cmd_row),   32'd0);
            check("rd_col",    32'(bus.cmd_col),   32'd1);
            check("rd_hready", 32'(bus.HREADY),    32'd0);
            if (i == 3) bus.cmd_ready = 1'b1;
            tick();
        end
        bus.cmd_ready = 1'b0;                     // RDWAIT #1
        check("rd_wait_cvalid", 32'(bus.cmd_valid), 32'd0);
        check("rd_wait_hready", 32'(bus.HREADY),    32'd0);
        tick();                                   // RDWAIT #2
        check("rd_wait2_hready", 32'(bus.HREADY), 32'd0);
        bus.rd_valid = 1'b1;
        bus.rd_data  = 32'h1234_5678;
        tick();                                   // DONE
        bus.rd_valid = 1'b0;
        check("rd_done_hready", 32'(bus.HREADY), 32'd1);
        check("rd_done_hrdata", bus.HRDATA,      32'h1234_5678);
        check("rd_done_hresp",  32'(bus.HRESP),  32'd0);
        tick();                                   // IDLE

        // stray rd_valid outside RDWAIT must be ignored
        bus.rd_valid = 1'b1;
        bus.rd_data  = 32'hFFFF_0000;
        tick();
        bus.rd_valid = 1'b0;
        check("stray_rdvalid_hrdata", bus.HRDATA, 32'h1234_5678);

        // ---------------- error responses ----------------
        addr_phase(32'h0000_0010, 1'b1, 3'b000);  // byte access
        tick();                                   // ERR1
        bus_idle();
        check("byte_err1_hready", 32'(bus.HREADY),    32'd0);
        check("byte_err1_hresp",  32'(bus.HRESP),     32'd1);
        check("byte_err1_cvalid", 32'(bus.cmd_valid), 32'd0);
        tick();                                   // ERR2
        check("byte_err2_hready", 32'(bus.HREADY),    32'd1);
        check("byte_err2_hresp",  32'(bus.HRESP),     32'd1);
        check("byte_err2_cvalid", 32'(bus.cmd_valid), 32'd0);
        tick();                                   // IDLE
        check("byte_after_hresp", 32'(bus.HRESP), 32'd0);

        addr_phase(32'h0000_0002, 1'b0, 3'b010);  // misaligned word
        tick();
        bus_idle();
        check("mis_err1_hready", 32'(bus.HREADY),    32'd0);
        check("mis_err1_hresp",  32'(bus.HRESP),     32'd1);
        check("mis_err1_cvalid", 32'(bus.cmd_valid), 32'd0);
        tick();
        check("mis_err2_hready", 32'(bus.HREADY),    32'd1);
        check("mis_err2_hresp",  32'(bus.HRESP),     32'd1);
        check("mis_err2_cvalid", 32'(bus.cmd_valid), 32'd0);
        tick();
        check("mis_after_hresp", 32'(bus.HRESP), 32'd0);

        // ---------------- back-to-back write then read ----------------
        addr_phase(32'h0000_0010, 1'b1, 3'b010);
        bus.cmd_ready = 1'b1;
        tick();                                   // ISSUE (write)
        bus_idle();
        bus.HWDATA = 32'hCAFE_F00D;
        #1;
        check("b2b_wr_wdata", bus.cmd_wdata,    32'hCAFE_F00D);
        check("b2b_wr_col",   32'(bus.cmd_col), 32'd4);
        tick();                                   // DONE: next NONSEQ here
        check("b2b_done_hready", 32'(bus.HREADY),    32'd1);
        check("b2b_done_cvalid", 32'(bus.cmd_valid), 32'd0);
        addr_phase(32'h0800_2004, 1'b0, 3'b010);
        tick();                                   // ISSUE (read)
        bus_idle();
        check("b2b_rd_cvalid", 32'(bus.cmd_valid), 32'd1);
        check("b2b_rd_cwrite", 32'(bus.cmd_write), 32'd0);
        check("b2b_rd_ba",     32'(bus.cmd_ba),    32'd2);
        check("b2b_rd_row",    32'(bus.cmd_row),   32'd2);
        check("b2b_rd_col",    32'(bus.cmd_col),   32'd1);
        check("b2b_rd_hready", 32'(bus.HREADY),    32'd0);
        check("b2b_rd_wdata",  bus.cmd_wdata,      32'hCAFE_F00D);
        tick();                                   // RDWAIT
        bus.cmd_ready = 1'b0;
        bus.rd_valid  = 1'b1;
        bus.rd_data   = 32'hA5A5_5A5A;
        tick();                                   // DONE
        bus.rd_valid = 1'b0;
        check("b2b_rd_hrdata", bus.HRDATA,      32'hA5A5_5A5A);
        check("b2b_rd_hready", 32'(bus.HREADY), 32'd1);
        tick();                                   // IDLE

        // ---------------- reset during RDWAIT ----------------
        addr_phase(32'h0000_0008, 1'b0, 3'b010);
        bus.cmd_ready = 1'b1;
        tick();                                   // ISSUE
        bus_idle();
        tick();                                   // RDWAIT
        bus.cmd_ready = 1'b0;
        check("rstrw_hready_pre", 32'(bus.HREADY), 32'd0);
        HRESET = 1'b0;
        #1;
        check_reset_outputs("rstrw_async");
        bus.rd_valid = 1'b1;
        bus.rd_data  = 32'h1111_1111;
        tick();
        HRESET = 1'b1;
        tick();                                   // rd_valid still high, in IDLE
        bus.rd_valid = 1'b0;
        check_reset_outputs("rstrw_after");

        // ---------------- BUSY / unselected transfers ----------------
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b01;
        bus.HADDR  = 32'h0000_0020;
        bus.HWRITE = 1'b1;
        tick();
        check("busy_hready", 32'(bus.HREADY),    32'd1);
        check("busy_hresp",  32'(bus.HRESP),     32'd0);
        check("busy_cvalid", 32'(bus.cmd_valid), 32'd0);
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b10;
        tick();
        check("nosel_hready", 32'(bus.HREADY),    32'd1);
        check("nosel_cvalid", 32'(bus.cmd_valid), 32'd0);
        bus_idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_ddr3_slave.md
AHB_DDR3_SLAVE -- requirements
Module: ahb_ddr3_slave

Interface
REQ-001 SHALL have parameter BA_BITS, default 3, meaning bank address width.
REQ-002 SHALL have parameter ROW_BITS, default 14, meaning row address width.
REQ-003 SHALL have parameter COL_BITS, default 10, meaning column address width.
REQ-004 SHALL have port HCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port HRESET, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have AHB slave inputs: HSEL (1), HADDR (32), HWRITE (1), HTRANS (2), HSIZE (3), HBURST (3), HWDATA (32).
REQ-007 SHALL have AHB slave outputs: HREADY (1), HRESP (2), HRDATA (32).
REQ-008 SHALL have controller-side outputs: cmd_valid (1), cmd_write (1), cmd_ba (BA_BITS), cmd_row (ROW_BITS), cmd_col (COL_BITS), cmd_wdata (32).
REQ-009 SHALL have controller-side inputs: cmd_ready (1), rd_valid (1), rd_data (32).

Function
REQ-010 SHALL use FSM states IDLE, ISSUE, RDWAIT, DONE, ERR1 and ERR2.
REQ-011 Accepted address phase SHALL be defined as HSEL=1, HREADY=1 and HTRANS[1]=1 (NONSEQ/SEQ), sampled in IDLE or DONE only.
REQ-012 HTRANS IDLE/BUSY, or HSEL=0, SHALL give a zero-wait OKAY response with no command issued.
REQ-013 On an accepted phase, SHALL latch HWRITE and decode cmd_col=HADDR[11:2], cmd_row=HADDR[25:12], cmd_ba=HADDR[28:26]; HADDR[31:29] ignored.
REQ-014 Accepted phase with HSIZE!=3'b010 or HADDR[1:0]!=0 SHALL go to ERR1; otherwise to ISSUE.
REQ-015 ERR1 SHALL drive HREADY=0, HRESP=2'b01 -> ERR2; ERR2 SHALL drive HREADY=1, HRESP=2'b01 -> IDLE; no command issued.
REQ-016 ISSUE SHALL drive HREADY=0, cmd_valid=1, cmd_write=latched HWRITE, and cmd_wdata=HWDATA (live, held stable by the master during the stalled data phase).
REQ-017 cmd_valid, cmd_write, cmd_ba, cmd_row, cmd_col and cmd_wdata SHALL remain stable until the cycle cmd_ready=1 is sampled; cmd_valid SHALL drop the following cycle.
REQ-018 In ISSUE with cmd_ready=1: write -> DONE; read -> RDWAIT.
REQ-019 RDWAIT SHALL hold HREADY=0 until rd_valid=1, latch rd_data into HRDATA, then -> DONE; rd_valid outside RDWAIT SHALL be ignored.
REQ-020 DONE SHALL drive HREADY=1, HRESP=OKAY; HRDATA holds the last read value; DONE evaluates the next address phase exactly as IDLE does (back-to-back transfers with no idle cycle).
REQ-021 HBURST SHALL be ignored; each beat of a burst is an independent single-word command.
REQ-022 HRESP SHALL be 2'b00 in every state except ERR1/ERR2.
REQ-023 Minimum latency: write 1 wait state (cmd_ready=1 in first ISSUE cycle); read 2 wait states (rd_valid=1 the cycle after handshake).
REQ-024 At most one command SHALL be outstanding; no new command issues before DONE.

Reset
REQ-025 HRESET=0 SHALL immediately force state IDLE, HREADY=1, HRESP=2'b00, HRDATA=0, cmd_valid=0, cmd_write=0, cmd_ba/row/col=0, cmd_wdata=0.
REQ-026 Reset during ISSUE or RDWAIT SHALL abandon the transfer; a later rd_valid SHALL NOT update HRDATA.
REQ-027 After HRESET rises, the first accepted address phase SHALL be evaluated in the first HCLK edge.

Verification
REQ-028 Write HADDR=0x0400_1008, HWDATA=0xDEADBEEF, cmd_ready=1 immediately -> cmd_ba=1, cmd_row=1, cmd_col=2, cmd_write=1, cmd_wdata=0xDEADBEEF; HREADY low 1 cycle.
REQ-029 Read HADDR=0x0000_0004, cmd_ready delayed 3 cycles, rd_data=0x12345678 2 cycles later -> cmd fields stable 4 cycles, HRDATA=0x12345678, HRESP=OKAY.
REQ-030 Byte access (HSIZE=0) or HADDR=0x2 -> HRESP=01 for two cycles, HREADY 0 then 1; cmd_valid never asserted.
REQ-031 Back-to-back write then read, second NONSEQ presented in DONE -> second command issued with no IDLE cycle between.
REQ-032 Assert HRESET during RDWAIT, then pulse rd_valid -> all outputs at reset values, HRDATA stays 0.
REQ-033 HTRANS=BUSY with HSEL=1 -> HREADY=1, HRESP=00, no cmd_valid.
